suma_mult_gen: RTL and testbench

- Parametrised successor of the fixed multiples-of-5-or-3 summer.
- Computes X = sum of all k, 1 <= k < n, that satisfy a selectable divisibility rule against two runtime divisors m1 and m2.
- Sequential, one candidate k per clock, using residue counters (no divider).
- Sits behind the Wishbone data path; operands come from wbs_dat_i fields, and results return on wbs_dat_o.

---
 rtl/suma_mult_gen.sv | 114 +++++++++++
 tb/tb_suma_mult_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/suma_mult_gen.sv
// Sums every k in [1, n) that is a multiple of m1 OR/AND m2, one candidate per clock.
// Residues k mod m1 / k mod m2 are tracked with wrap-around counters instead of a divider.
module suma_mult_gen #(
    parameter int N_W   = 16,
    parameter int M_W   = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    input  logic [M_W-1:0]   m1,
    input  logic [M_W-1:0]   m2,
    input  logic             mode,
    output logic [ACC_W-1:0] X,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err,
    output logic [1:0]       state_o
);
    // start is taken only while busy==0 (IDLE or DONE); busy stays high until the
    // edge that raises done, and done is a single-cycle pulse carrying X/ovf/err.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t           state_q;
    logic [N_W-1:0]   n_q, k_q;
    logic [M_W-1:0]   m1_q, m2_q, r1_q, r2_q;
    logic             mode_q, ovf_int_q, err_int_q;
    logic [ACC_W-1:0] acc_q, x_q;
    logic             busy_q, done_q, ovf_q, err_q;

    logic [M_W-1:0]   r1_d, r2_d;
    logic             hit_d;
    logic [ACC_W:0]   sum_d;

    always_comb begin
        r1_d  = (r1_q == m1_q - M_W'(1)) ? '0 : r1_q + M_W'(1);
        r2_d  = (r2_q == m2_q - M_W'(1)) ? '0 : r2_q + M_W'(1);
        hit_d = mode_q ? ((r1_q == '0) && (r2_q == '0))
                       : ((r1_q == '0) || (r2_q == '0));
        // Extra top bit catches the carry out of the accumulator.
        sum_d = {1'b0, acc_q} + {1'b0, ACC_W'(k_q)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            k_q       <= '0;
            m1_q      <= '0;
            m2_q      <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            mode_q    <= 1'b0;
            ovf_int_q <= 1'b0;
            err_int_q <= 1'b0;
            acc_q     <= '0;
            x_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        n_q       <= n;
                        m1_q      <= m1;
                        m2_q      <= m2;
                        mode_q    <= mode;
                        k_q       <= N_W'(1);
                        r1_q      <= (m1 == M_W'(1)) ? '0 : M_W'(1);
                        r2_q      <= (m2 == M_W'(1)) ? '0 : M_W'(1);
                        acc_q     <= '0;
                        ovf_int_q <= 1'b0;
                        err_int_q <= (m1 == '0) || (m2 == '0);
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (err_int_q || (k_q >= n_q)) begin
                        x_q     <= err_int_q ? '0 : acc_q;
                        ovf_q   <= ovf_int_q;
                        err_q   <= err_int_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        if (hit_d) begin
                            acc_q <= sum_d[ACC_W-1:0];
                            if (sum_d[ACC_W]) ovf_int_q <= 1'b1;
                        end
                        k_q  <= k_q + N_W'(1);
                        r1_q <= r1_d;
                        r2_q <= r2_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign X       = x_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign err     = err_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_suma_mult_gen.sv
// Bench for suma_mult_gen: drives a 32-bit and a 16-bit accumulator instance with the
// same operations and checks both against a plain-arithmetic model through a queue.
module tb_suma_mult_gen;
    localparam int EW = 73;  // {sum[39:0], err, done_cycle[31:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n = '0;
    logic [7:0]  m1 = '0;
    logic [7:0]  m2 = '0;
    logic        mode = 1'b0;

    logic [31:0] x32;
    logic        busy, done, ovf, err;
    logic [1:0]  st32;
    logic [15:0] x16;
    logic        busy16, done16, ovf16, err16;
    logic [1:0]  st16;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];

    suma_mult_gen #(.N_W(16), .M_W(8), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .m1(m1), .m2(m2), .mode(mode),
        .X(x32), .busy(busy), .done(done), .ovf(ovf), .err(err), .state_o(st32)
    );

    suma_mult_gen #(.N_W(16), .M_W(8), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .n(n), .m1(m1), .m2(m2), .mode(mode),
        .X(x16), .busy(busy16), .done(done16), .ovf(ovf16), .err(err16), .state_o(st16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: brute-force divisibility test over every candidate below n.
    function automatic logic [39:0] model_sum(input int nn, input int a, input int b, input bit md);
        longint s = 0;
        if (a == 0 || b == 0) return '0;
        for (int k = 1; k < nn; k++) begin
            bit d1, d2;
            d1 = (k % a) == 0;
            d2 = (k % b) == 0;
            if (md ? (d1 && d2) : (d1 || d2)) s += k;
        end
        return 40'(s);
    endfunction

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic issue(input int nn, input int a, input int b, input bit md, output int lat);
        logic [39:0] s;
        bit e;
        e   = (a == 0) || (b == 0);
        s   = model_sum(nn, a, b, md);
        lat = e ? 1 : ((nn < 1) ? 1 : nn);
        exp_q.push_back({s, e, 32'(cyc + 1 + lat)});
        n     = 16'(nn);
        m1    = 8'(a);
        m2    = 8'(b);
        mode  = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int busy_exp);
        int busy_cnt = 0;
        bit seen = 0;
        for (int t = 0; t < 70000; t++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_cycles", 64'(busy_cnt), 64'(busy_exp));
    endtask

    task automatic run(input int nn, input int a, input int b, input bit md);
        int lat;
        @(negedge clk);
        issue(nn, a, b, md, lat);
        wait_done(lat);
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [39:0]   s;
        if (!rst && (done || done16)) begin
            chk("done_match_16", 64'(done16), 64'(done));
            chk("busy_at_done", 64'(busy), 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with empty queue at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                s = e[72:33];
                chk("done_cycle", 64'(cyc), 64'(e[31:0]));
                chk("x32", 64'(x32), 64'(s[31:0]));
                chk("ovf32", 64'(ovf), 64'(s[39:32] != '0));
                chk("err32", 64'(err), 64'(e[32]));
                chk("x16", 64'(x16), 64'(s[15:0]));
                chk("ovf16", 64'(ovf16), 64'(s[39:16] != '0));
                chk("err16", 64'(err16), 64'(e[32]));
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_x32"}, 64'(x32), 64'd0);
        chk({tag, "_x16"}, 64'(x16), 64'd0);
        chk({tag, "_busy"}, 64'(busy | busy16), 64'd0);
        chk({tag, "_done"}, 64'(done | done16), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf | ovf16), 64'd0);
        chk({tag, "_err"}, 64'(err | err16), 64'd0);
        chk({tag, "_state"}, 64'(st32), 64'd0);
    endtask

    initial begin
        int lat;
        #1;
        chk_reset_state("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(10, 3, 5, 0);
        run(1000, 3, 5, 0);
        run(100, 3, 5, 1);
        run(50, 0, 5, 0);
        run(10, 3, 5, 0);
        run(1000, 1, 1, 0);
        run(0, 3, 5, 0);
        run(1, 3, 5, 0);

        // start pulses during a run must not disturb the latched operands
        @(negedge clk);
        issue(20, 3, 5, 0, lat);
        repeat (2) @(negedge clk);
        n = 16'd5; m1 = 8'd2; m2 = 8'd7; mode = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(lat - 5);

        // back-to-back: new start while done is high
        @(negedge clk);
        issue(12, 2, 3, 1, lat);
        wait_done(lat);
        issue(30, 4, 6, 0, lat);
        wait_done(lat);

        run(60, 7, 7, 0);
        run(60, 7, 7, 1);
        run(2, 1, 9, 1);

        for (int i = 0; i < 25; i++) begin
            run(int'($urandom_range(0, 300)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 12)), bit'($urandom_range(0, 1)));
        end

        // asynchronous reset part-way through a long run
        @(negedge clk);
        issue(1000, 3, 5, 0, lat);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_state("midrun_reset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        run(10, 3, 5, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
